// File: rtl/pmem_arb_types.sv
// Shared types and sizing helpers for the pmem line arbiter.
package pmem_arb_types;

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } arb_state_t;

    function automatic int beats_f(input int line_bits, input int beat_bits);
        return line_bits / beat_bits;
    endfunction

    // Keep at least one counter bit so a single-beat line still elaborates.
    function automatic int cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    function automatic int align_w_f(input int line_bits);
        return $clog2(line_bits / 8);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational priority picker: first set request at or after ptr_i, with wrap.
module rr_grant #(
    parameter int NUM_CH = 2,
    parameter int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [IW-1:0]     idx_o,
    output logic              valid_o
);

    logic [2*NUM_CH-1:0] rot;

    always_comb begin
        rot     = {req_i, req_i} >> ptr_i;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!valid_o && rot[i]) begin
                valid_o = 1'b1;
                idx_o   = IW'((int'(ptr_i) + i) % NUM_CH);
            end
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates whole-line cache reads/writebacks onto one burst pmem port.
// state    | meaning
// IDLE     | waiting for any channel request; grant latched on exit
// RD_BURST | pmem_read high, collecting beats into ch_rdata
// WR_BURST | pmem_write high, presenting latched line beat by beat
// DONE     | one-cycle ch_resp pulse to the granted channel
module pmem_arbiter
    import pmem_arb_types::*;
#(
    parameter int NUM_CH    = 2,
    parameter int LINE_BITS = 256,
    parameter int BEAT_BITS = 64,
    parameter int ADDR_BITS = 32,
    parameter int RR_MODE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ch_read,
    input  logic [NUM_CH-1:0]             ch_write,
    input  logic [NUM_CH*ADDR_BITS-1:0]   ch_address,
    input  logic [NUM_CH*LINE_BITS-1:0]   ch_wdata,
    output logic [LINE_BITS-1:0]          ch_rdata,
    output logic [NUM_CH-1:0]             ch_resp,
    output logic                          pmem_read,
    output logic                          pmem_write,
    output logic [ADDR_BITS-1:0]          pmem_address,
    output logic [BEAT_BITS-1:0]          pmem_wdata,
    input  logic [BEAT_BITS-1:0]          pmem_rdata,
    input  logic                          pmem_resp
);

    localparam int BEATS = beats_f(LINE_BITS, BEAT_BITS);
    localparam int CW    = cnt_w_f(BEATS);
    localparam int IW    = $clog2(NUM_CH);
    localparam int AW    = align_w_f(LINE_BITS);
    localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

    arb_state_t            state_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         gnt_q, rr_ptr_q, rr_ptr_d;
    logic [LINE_BITS-1:0]  line_q, rdata_q;
    logic [NUM_CH-1:0]     resp_q;
    logic                  pmem_read_q, pmem_write_q;
    logic [ADDR_BITS-1:0]  pmem_addr_q;
    logic [BEAT_BITS-1:0]  pmem_wdata_q;

    logic [IW-1:0]         win_idx, ptr;
    logic                  win_valid, last_beat;
    logic [ADDR_BITS-1:0]  win_addr;
    logic [LINE_BITS-1:0]  win_line;

    assign ptr       = (RR_MODE != 0) ? rr_ptr_q : '0;
    assign win_addr  = ch_address[win_idx*ADDR_BITS +: ADDR_BITS];
    assign win_line  = ch_wdata[win_idx*LINE_BITS +: LINE_BITS];
    assign cnt_d     = cnt_q + CW'(1);
    assign last_beat = (cnt_q == CW'(BEATS - 1));
    assign rr_ptr_d  = (gnt_q == IW'(NUM_CH - 1)) ? '0 : gnt_q + IW'(1);

    rr_grant #(.NUM_CH(NUM_CH), .IW(IW)) u_grant (
        .req_i   (ch_read | ch_write),
        .ptr_i   (ptr),
        .idx_o   (win_idx),
        .valid_o (win_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gnt_q        <= '0;
            rr_ptr_q     <= '0;
            line_q       <= '0;
            rdata_q      <= '0;
            resp_q       <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (win_valid) begin
                        gnt_q       <= win_idx;
                        line_q      <= win_line;
                        pmem_addr_q <= {win_addr[ADDR_BITS-1:AW], AW'(0)};
                        // write wins when a channel raises both
                        if (ch_write[win_idx]) begin
                            state_q      <= WR_BURST;
                            pmem_write_q <= 1'b1;
                            pmem_wdata_q <= win_line[BEAT_BITS-1:0];
                        end else begin
                            state_q     <= RD_BURST;
                            pmem_read_q <= 1'b1;
                        end
                    end
                end
                RD_BURST: begin
                    if (pmem_resp) begin
                        rdata_q[cnt_q*BEAT_BITS +: BEAT_BITS] <= pmem_rdata;
                        if (last_beat) begin
                            state_q     <= DONE;
                            pmem_read_q <= 1'b0;
                            resp_q      <= ONE_HOT0 << gnt_q;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                WR_BURST: begin
                    if (pmem_resp) begin
                        if (last_beat) begin
                            state_q      <= DONE;
                            pmem_write_q <= 1'b0;
                            resp_q       <= ONE_HOT0 << gnt_q;
                        end else begin
                            cnt_q        <= cnt_d;
                            pmem_wdata_q <= line_q[cnt_d*BEAT_BITS +: BEAT_BITS];
                        end
                    end
                end
                DONE: begin
                    resp_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    if (RR_MODE != 0) rr_ptr_q <= rr_ptr_d;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_rdata     = rdata_q;
    assign ch_resp      = resp_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_addr_q;
    assign pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter share one stimulus.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   ch_read, ch_write;
    logic [63:0]  ch_address;
    logic [511:0] ch_wdata;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;

    logic [255:0] f_rdata, r_rdata;
    logic [1:0]   f_resp, r_resp;
    logic         f_pread, r_pread, f_pwrite, r_pwrite;
    logic [31:0]  f_paddr, r_paddr;
    logic [63:0]  f_pwdata, r_pwdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pmem_arbiter #(.NUM_CH(2), .LINE_BITS(256), .BEAT_BITS(64), .ADDR_BITS(32), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(f_rdata), .ch_resp(f_resp),
        .pmem_read(f_pread), .pmem_write(f_pwrite), .pmem_address(f_paddr),
        .pmem_wdata(f_pwdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    pmem_arbiter #(.NUM_CH(2), .LINE_BITS(256), .BEAT_BITS(64), .ADDR_BITS(32), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
        .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_rdata(r_rdata), .ch_resp(r_resp),
        .pmem_read(r_pread), .pmem_write(r_pwrite), .pmem_address(r_paddr),
        .pmem_wdata(r_pwdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic         rd;
        logic         wr;
        int           ch;
        logic [31:0]  addr;
        logic [255:0] line;
        logic [31:0]  exp_addr;
        logic         exp_write;
        logic [1:0]   exp_resp;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        ch_read = 2'b00;
        ch_write = 2'b00;
        pmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Entered at the negedge of the first burst cycle; leaves at the DONE-cycle negedge.
    task automatic burst(input string tag, input logic [255:0] line,
                         input logic [1:0] exp_f, input logic [1:0] exp_r);
        for (int b = 0; b < 4; b++) begin
            pmem_resp = 1'b1;
            pmem_rdata = line[b*64 +: 64];
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        chk({tag, ".fix.resp"}, f_resp, exp_f);
        chk({tag, ".rr.resp"}, r_resp, exp_r);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic [6:0]  pat;
        logic [63:0] bt[4];
        int          cnt;

        vecs[0] = '{1'b1, 1'b0, 0, 32'h0000_1064,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    32'h0000_1060, 1'b0, 2'b01};
        vecs[1] = '{1'b0, 1'b1, 1, 32'h0000_2000,
                    {64'hD, 64'hC, 64'hB, 64'hA},
                    32'h0000_2000, 1'b1, 2'b10};
        vecs[2] = '{1'b1, 1'b0, 1, 32'hABCD_EF7F,
                    {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0F0F_F0F0_0F0F_F0F0},
                    32'hABCD_EF60, 1'b0, 2'b10};
        vecs[3] = '{1'b1, 1'b1, 0, 32'h0000_003F,
                    {64'h1234, 64'h5678, 64'h9ABC, 64'hDEF0},
                    32'h0000_0020, 1'b1, 2'b01};
        vecs[4] = '{1'b0, 1'b1, 0, 32'hFFFF_FFFF,
                    {64'hCAFE_0003, 64'hCAFE_0002, 64'hCAFE_0001, 64'hCAFE_0000},
                    32'hFFFF_FFE0, 1'b1, 2'b01};

        rst = 1'b0;
        ch_read = 2'b00;
        ch_write = 2'b00;
        ch_address = '0;
        ch_wdata = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("rst.fix.outs", {f_resp, f_pread, f_pwrite, f_paddr, f_pwdata}, '0);
        chk("rst.rr.outs", {r_resp, r_pread, r_pwrite, r_paddr, r_pwdata}, '0);
        chk("rst.fix.rdata", f_rdata, '0);
        chk("rst.rr.rdata", r_rdata, '0);
        rst = 1'b1;
        @(negedge clk);

        // Single-requester transactions with ideal pmem: latency, alignment, data order.
        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            ch_read = v.rd ? (2'b01 << v.ch) : 2'b00;
            ch_write = v.wr ? (2'b01 << v.ch) : 2'b00;
            ch_address = {v.addr, v.addr};
            ch_wdata = {v.line, v.line};
            @(negedge clk);
            chk($sformatf("v%0d.fix.req", i), {f_pread, f_pwrite}, {~v.exp_write, v.exp_write});
            chk($sformatf("v%0d.rr.req", i), {r_pread, r_pwrite}, {~v.exp_write, v.exp_write});
            chk($sformatf("v%0d.fix.addr", i), f_paddr, v.exp_addr);
            chk($sformatf("v%0d.rr.addr", i), r_paddr, v.exp_addr);
            for (int b = 0; b < 4; b++) begin
                if (v.exp_write) begin
                    chk($sformatf("v%0d.fix.wdata%0d", i, b), f_pwdata, v.line[b*64 +: 64]);
                    chk($sformatf("v%0d.rr.wdata%0d", i, b), r_pwdata, v.line[b*64 +: 64]);
                end
                chk($sformatf("v%0d.early_resp%0d", i, b), {f_resp, r_resp}, 4'b0);
                pmem_resp = 1'b1;
                pmem_rdata = v.line[b*64 +: 64];
                @(negedge clk);
            end
            pmem_resp = 1'b0;
            chk($sformatf("v%0d.fix.resp", i), f_resp, v.exp_resp);
            chk($sformatf("v%0d.rr.resp", i), r_resp, v.exp_resp);
            chk($sformatf("v%0d.done_req", i), {f_pread, f_pwrite, r_pread, r_pwrite}, 4'b0);
            if (!v.exp_write) begin
                chk($sformatf("v%0d.fix.rdata", i), f_rdata, v.line);
                chk($sformatf("v%0d.rr.rdata", i), r_rdata, v.line);
            end
            ch_read = 2'b00;
            ch_write = 2'b00;
            @(negedge clk);
            chk($sformatf("v%0d.pulse_end", i), {f_resp, r_resp}, 4'b0);
        end

        // Simultaneous reads from reset: ch0 first, then ch1.
        do_reset();
        ch_address = {32'h0000_2040, 32'h0000_1064};
        ch_read = 2'b11;
        @(negedge clk);
        chk("a.fix.addr0", f_paddr, 32'h0000_1060);
        chk("a.rr.addr0", r_paddr, 32'h0000_1060);
        burst("a.t0", 256'h0, 2'b01, 2'b01);
        ch_read = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("a.fix.addr1", f_paddr, 32'h0000_2040);
        chk("a.rr.addr1", r_paddr, 32'h0000_2040);
        burst("a.t1", 256'h0, 2'b10, 2'b10);
        ch_read = 2'b00;
        @(negedge clk);

        // Continuous requesters: four grants alternate ch0, ch1, ch0, ch1.
        do_reset();
        ch_address = {32'h0000_2040, 32'h0000_1000};
        ch_read = 2'b11;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (t > 0) ch_read[1 - (t % 2)] = 1'b1;
            chk($sformatf("b.t%0d.rr.addr", t), r_paddr, (t % 2 == 1) ? 32'h0000_2040 : 32'h0000_1000);
            chk($sformatf("b.t%0d.fix.addr", t), f_paddr, (t % 2 == 1) ? 32'h0000_2040 : 32'h0000_1000);
            burst($sformatf("b.t%0d", t), 256'h0, (t % 2 == 1) ? 2'b10 : 2'b01, (t % 2 == 1) ? 2'b10 : 2'b01);
            ch_read[t % 2] = 1'b0;
            @(negedge clk);
        end

        // Pointer divergence: after ch0 is served, rr favours ch1, fixed keeps ch0.
        do_reset();
        ch_address = {32'h0000_2000, 32'h0000_1000};
        ch_read = 2'b01;
        @(negedge clk);
        burst("c.t0", 256'h0, 2'b01, 2'b01);
        ch_read = 2'b00;
        @(negedge clk);
        @(negedge clk);
        ch_read = 2'b11;
        @(negedge clk);
        chk("c.fix.addr", f_paddr, 32'h0000_1000);
        chk("c.rr.addr", r_paddr, 32'h0000_2000);
        ch_read = 2'b00;
        burst("c.withdrawn", 256'h0, 2'b01, 2'b10);

        // Gapped pmem_resp read.
        ch_address = {32'h0000_2000, 32'h0000_3000};
        @(negedge clk);
        @(negedge clk);
        ch_read = 2'b01;
        @(negedge clk);
        pat = 7'b1011001;
        bt[0] = 64'h1111_1111_1111_1111;
        bt[1] = 64'h2222_2222_2222_2222;
        bt[2] = 64'h3333_3333_3333_3333;
        bt[3] = 64'h4444_4444_4444_4444;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("d.hold%0d", i), {f_pread, r_pread, f_resp, r_resp}, 6'b110000);
            pmem_resp = pat[i];
            pmem_rdata = pat[i] ? bt[cnt] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (pat[i]) cnt++;
            @(negedge clk);
        end
        pmem_resp = 1'b0;
        chk("d.fix.resp", f_resp, 2'b01);
        chk("d.rr.resp", r_resp, 2'b01);
        chk("d.pread_low", {f_pread, r_pread}, 2'b00);
        chk("d.fix.rdata", f_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        chk("d.rr.rdata", r_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
        ch_read = 2'b00;
        @(negedge clk);
        chk("d.rdata_holds", f_rdata, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        // Reset after two beats of a read aborts at once.
        @(negedge clk);
        ch_address = {32'h0000_2000, 32'h0000_4000};
        ch_read = 2'b01;
        @(negedge clk);
        chk("e.started", {f_pread, r_pread}, 2'b11);
        pmem_resp = 1'b1;
        pmem_rdata = 64'hAAAA;
        @(negedge clk);
        pmem_rdata = 64'hBBBB;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("e.fix.abort", {f_pread, f_resp, f_paddr}, '0);
        chk("e.rr.abort", {r_pread, r_resp, r_paddr}, '0);
        chk("e.fix.rdata", f_rdata, '0);
        ch_read = 2'b00;
        pmem_resp = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("e.quiet%0d", i), {f_pread, r_pread, f_resp, r_resp}, 6'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Parametrised arbiter between NUM_CH line-granular cache requesters (I-cache = ch0, D-cache = ch1 by default) and the single burst physical-memory port.
- Lets the pipeline run on real pmem instead of split magic memory.
- Serialises whole-line reads and writebacks into BEAT_BITS-wide bursts.
- Grant policy is selectable: fixed priority or round-robin.

Parameters:
- NUM_CH, 2, number of requesting channels (>=2).
- LINE_BITS, 256, cache-line width in bits.
- BEAT_BITS, 64, pmem data width per beat; LINE_BITS must be an integer multiple of it.
- ADDR_BITS, 32, address width.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-low (rst = 0 resets).
- ch_read  in  NUM_CH  per-channel line-read request.
- ch_write  in  NUM_CH  per-channel line-write request.
- ch_address  in  NUM_CH*ADDR_BITS  per-channel address; channel i occupies slice i.
- ch_wdata  in  NUM_CH*LINE_BITS  per-channel write line.
- ch_rdata  out  LINE_BITS  assembled read line, shared by all channels.
- ch_resp  out  NUM_CH  one-hot, one-cycle completion pulse.
- pmem_read  out  1  burst read request.
- pmem_write  out  1  burst write request.
- pmem_address  out  ADDR_BITS  line-aligned burst address.
- pmem_wdata  out  BEAT_BITS  current write beat.
- pmem_rdata  in  BEAT_BITS  read beat.
- pmem_resp  in  1  one beat transferred this cycle.

Behaviour:
- BEATS = LINE_BITS/BEAT_BITS. Beat counter width is clog2(BEATS).
- Line alignment: pmem_address = granted address with its low clog2(LINE_BITS/8) bits forced to 0.
- Reset (rst = 0, asynchronous):
  - state = IDLE; beat counter = 0.
  - rr pointer = 0; granted channel = 0.
  - ch_rdata = 0, ch_resp = 0.
  - pmem_read, pmem_write, pmem_address, pmem_wdata = 0.
  - Reset mid-burst aborts immediately; pmem request drops in the same cycle, and no resp is issued.
- States and transitions:
  - IDLE: if any channel has read or write asserted, latch the winner's index, op, address and wdata. Go to RD_BURST or WR_BURST. Beat counter = 0.
  - RD_BURST: pmem_read = 1 and pmem_address held constant. On each pmem_resp, pmem_rdata goes into ch_rdata beat slot [cnt] (beat 0 = bits BEAT_BITS-1:0) and cnt increments. On the resp for beat BEATS-1, go to DONE.
  - WR_BURST: pmem_write = 1, pmem_wdata = latched line beat [cnt]. Advance on pmem_resp. Last beat goes to DONE.
  - DONE: ch_resp[granted] = 1 for exactly this cycle; pmem_read and pmem_write = 0. Then go to IDLE. If RR_MODE = 1, the rr pointer becomes (granted+1) mod NUM_CH.
- pmem_resp gaps: cycles without resp simply hold state; beats need not be consecutive.
- ch_rdata is valid in the DONE cycle and holds until the next read burst writes beats into it.
- Arbitration:
  - Fixed mode: lowest requesting index wins.
  - Round-robin mode: first requesting index at or after the pointer, searching with wrap-around.
- Requester rules:
  - A requester holds its request until it sees ch_resp, then deasserts next cycle. The IDLE after DONE therefore never re-grants a stale request.
  - Request withdrawn mid-burst: ignored; the burst completes and ch_resp still pulses.
  - Request inputs of non-granted channels are ignored during a burst.
- read and write asserted together on one channel: write wins.
- Latency (pmem_resp on every cycle):
  - Request seen in IDLE at cycle k.
  - pmem request high from k+1; beats at k+1..k+BEATS.
  - ch_resp at k+BEATS+1.
- pmem_resp in IDLE or DONE: ignored.

Decomposition:
- Package pmem_arb_types holds:
  - arb_state_t enum {IDLE, RD_BURST, WR_BURST, DONE};
  - the BEATS/clog2 constant functions.
- Sub-module rr_grant: combinational NUM_CH-wide priority picker, given request vector and start pointer (pointer tied to 0 in fixed mode). Outputs grant index and a valid flag.

Test Plan:
- RR_MODE=0, ch0 and ch1 read simultaneously, ch0 addr 0x0000_1064 -> ch0 served first; pmem_address = 0x0000_1060; ch1 served after the DONE/IDLE.
- RR_MODE=1, both channels requesting continuously for 4 transactions -> grants alternate ch0, ch1, ch0, ch1.
- ch1 write, wdata = {64'hD, 64'hC, 64'hB, 64'hA} -> pmem_wdata = A, B, C, D in order. ch_resp = 2'b10 one cycle after the 4th resp.
- Read with pmem_resp pattern 1,0,0,1,1,0,1 and beats 11..,22..,33..,44.. -> ch_rdata = {44..,33..,22..,11..}; pmem_read held high throughout.
- rst driven low after beat 2 of a read -> pmem_read = 0 in the same cycle. After release: state IDLE and no ch_resp pulse.
- Ideal pmem (resp every cycle) -> request cycle k yields ch_resp at k+5 for a 256/64 line.
